// File: rtl/bus_arbiter4.sv
// Four-requester round-robin bus arbiter with bounded bursts and a registered
// 4:1 32-bit data mux; a mandatory one-cycle idle turnaround follows every release.
module bus_arbiter4 #(
    parameter int MAX_BURST = 4
) (
    input  logic        CLK,
    input  logic        CLRN,
    input  logic [3:0]  REQ,
    input  logic [31:0] D0,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [31:0] D3,
    output logic [3:0]  GNT,
    output logic [1:0]  SEL,
    output logic [31:0] DOUT,
    output logic        DVALID,
    output logic        BUSY
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [3:0]  beat_cnt;
    logic [1:0]  winner;
    logic [31:0] mux_out;
    logic        last_beat;

    // Descending scan so the requester closest to ptr is the last to write winner.
    always_comb begin
        winner = ptr; // NOTE: assign a default first so the search cannot infer a latch
        for (int j = 3; j >= 0; j--) begin
            if (REQ[ptr + 2'(j)]) begin
                winner = ptr + 2'(j);
            end
        end
    end

    // The data path follows the registered owner index, never the request vector.
    always_comb begin
        case (SEL)
            2'd0:    mux_out = D0;
            2'd1:    mux_out = D1;
            2'd2:    mux_out = D2;
            default: mux_out = D3;
        endcase
    end

    assign last_beat = (beat_cnt == 4'(MAX_BURST - 1));
    assign BUSY      = (state == OWN);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values
    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state    <= IDLE;
            GNT      <= 4'b0000;
            SEL      <= 2'd0;
            DOUT     <= 32'd0;
            DVALID   <= 1'b0;
            ptr      <= 2'd0;
            beat_cnt <= 4'd0;
        end else begin
            DVALID <= 1'b0;
            case (state)
                IDLE: begin
                    if (|REQ) begin
                        GNT      <= 4'b0001 << winner;
                        SEL      <= winner;
                        beat_cnt <= 4'd0;
                        state    <= OWN;
                    end else begin
                        GNT <= 4'b0000;
                    end
                end
                OWN: begin
                    if (REQ[SEL]) begin
                        DOUT     <= mux_out;
                        DVALID   <= 1'b1;
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                    // Release on a dropped request or on the final permitted beat.
                    if (!REQ[SEL] || last_beat) begin
                        GNT   <= 4'b0000;
                        ptr   <= SEL + 2'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
